// File: rtl/rrv64_core_vec_param_pkg.sv
// Vector core parameters shared by the regfile writeback path.
// Holds the writeback entry layout used by the arbiter and its buffers.
package rrv64_core_vec_param_pkg;

    localparam int VREG_ADDR_WIDTH = 6;
    localparam int VFULEN          = 64;
    localparam int VRF_WPORT_NUM   = 2;

    typedef struct packed {
        logic [VREG_ADDR_WIDTH-1:0] waddr;
        logic [VFULEN-1:0]          wmask;
        logic [VFULEN-1:0]          wdata;
    } vrf_wb_entry_t;

endpackage

// File: rtl/vrf_wb_fifo.sv
// In-order writeback buffer for one functional-unit source.
// Head is read combinationally; a full buffer refuses pushes outright.
module vrf_wb_fifo
    import rrv64_core_vec_param_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          push_i,
    input  vrf_wb_entry_t din_i,
    input  logic          pop_i,
    output vrf_wb_entry_t dout_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    vrf_wb_entry_t mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rptr_q];

    // Pointer and occupancy next state; pointers wrap on power-of-two depth.
    always_comb begin
        wptr_d = wptr_q + AW'(do_push);
        rptr_d = rptr_q + AW'(do_pop);
        cnt_d  = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Control state register; reset drops every buffered entry.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is unused.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// Two-source vector regfile writeback arbiter.
// Port 0 wins same-address races; a starve counter lets port 1 through.
module vrf_wb_arbiter
    import rrv64_core_vec_param_pkg::*;
#(
    parameter int WB_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       src0_vld,
    output logic                       src0_rdy,
    input  logic [VREG_ADDR_WIDTH-1:0] src0_waddr,
    input  logic [VFULEN-1:0]          src0_wmask,
    input  logic [VFULEN-1:0]          src0_wdata,
    input  logic                       src1_vld,
    output logic                       src1_rdy,
    input  logic [VREG_ADDR_WIDTH-1:0] src1_waddr,
    input  logic [VFULEN-1:0]          src1_wmask,
    input  logic [VFULEN-1:0]          src1_wdata,
    output logic                       wr0_vld,
    output logic                       wr1_vld,
    input  logic                       wr0_conflict,
    input  logic                       wr1_conflict,
    output logic [VREG_ADDR_WIDTH-1:0] waddr0,
    output logic [VREG_ADDR_WIDTH-1:0] waddr1,
    output logic [VFULEN-1:0]          wmask0,
    output logic [VFULEN-1:0]          wmask1,
    output logic [VFULEN-1:0]          wdata0,
    output logic [VFULEN-1:0]          wdata1,
    output logic                       idle
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    vrf_wb_entry_t             din0, din1, head0, head1;
    logic                      full0, full1, empty0, empty1;
    logic [VRF_WPORT_NUM-1:0]  wr_vld, wr_pop;
    logic                      addr_hit, yield_now;
    logic [CW-1:0]             starve_q, starve_d;
    logic                      yield_q, yield_d;

    assign din0 = '{waddr: src0_waddr, wmask: src0_wmask, wdata: src0_wdata};
    assign din1 = '{waddr: src1_waddr, wmask: src1_wmask, wdata: src1_wdata};

    vrf_wb_fifo #(.DEPTH(WB_FIFO_DEPTH)) u_fifo0 (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .push_i  (src0_vld),
        .din_i   (din0),
        .pop_i   (wr_pop[0]),
        .dout_o  (head0),
        .full_o  (full0),
        .empty_o (empty0)
    );

    vrf_wb_fifo #(.DEPTH(WB_FIFO_DEPTH)) u_fifo1 (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .push_i  (src1_vld),
        .din_i   (din1),
        .pop_i   (wr_pop[1]),
        .dout_o  (head1),
        .full_o  (full1),
        .empty_o (empty1)
    );

    assign src0_rdy = ~full0;
    assign src1_rdy = ~full1;
    assign idle     = empty0 & empty1;

    // Port 0 steps aside for a single cycle once port 1 has starved long enough.
    assign yield_now = (starve_q == LIMIT) & ~yield_q;
    assign addr_hit  = ~empty0 & ~empty1 & (head0.waddr == head1.waddr);
    assign wr_vld[0] = ~empty0 & ~yield_now;
    assign wr_vld[1] = ~empty1 & ~(addr_hit & wr_vld[0]);
    assign wr_pop[0] = wr_vld[0] & ~wr0_conflict;
    assign wr_pop[1] = wr_vld[1] & ~wr1_conflict;

    assign wr0_vld = wr_vld[0];
    assign wr1_vld = wr_vld[1];
    assign waddr0  = wr_vld[0] ? head0.waddr : '0;
    assign wmask0  = wr_vld[0] ? head0.wmask : '0;
    assign wdata0  = wr_vld[0] ? head0.wdata : '0;
    assign waddr1  = wr_vld[1] ? head1.waddr : '0;
    assign wmask1  = wr_vld[1] ? head1.wmask : '0;
    assign wdata1  = wr_vld[1] ? head1.wdata : '0;

    // Starve counter and yield-taken flag next state.
    always_comb begin
        starve_d = starve_q;
        yield_d  = yield_q;
        if (wr_pop[1] | empty1) begin
            starve_d = '0;
            yield_d  = 1'b0;
        end else begin
            if (yield_now) begin
                yield_d = 1'b1;
            end
            if (wr_vld[1] & wr1_conflict & (starve_q != LIMIT)) begin
                starve_d = starve_q + CW'(1);
            end
        end
    end

    // Starvation tracking registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_q <= '0;
            yield_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            yield_q  <= yield_d;
        end
    end

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Self-checking bench for vrf_wb_arbiter: queue model plus directed tests.
// Inputs change on the falling edge; outputs are compared there too.
module tb_vrf_wb_arbiter;
    import rrv64_core_vec_param_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam logic [VFULEN-1:0] ONES = '1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic src0_vld = 0, src1_vld = 0;
    logic src0_rdy, src1_rdy;
    logic [VREG_ADDR_WIDTH-1:0] src0_waddr = '0, src1_waddr = '0;
    logic [VFULEN-1:0] src0_wmask = '0, src1_wmask = '0;
    logic [VFULEN-1:0] src0_wdata = '0, src1_wdata = '0;
    logic wr0_vld, wr1_vld;
    logic wr0_conflict = 0, wr1_conflict = 0;
    logic [VREG_ADDR_WIDTH-1:0] waddr0, waddr1;
    logic [VFULEN-1:0] wmask0, wmask1, wdata0, wdata1;
    logic idle;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    vrf_wb_arbiter #(.WB_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rstn(rstn),
        .src0_vld(src0_vld), .src0_rdy(src0_rdy),
        .src0_waddr(src0_waddr), .src0_wmask(src0_wmask),
        .src0_wdata(src0_wdata),
        .src1_vld(src1_vld), .src1_rdy(src1_rdy),
        .src1_waddr(src1_waddr), .src1_wmask(src1_wmask),
        .src1_wdata(src1_wdata),
        .wr0_vld(wr0_vld), .wr1_vld(wr1_vld),
        .wr0_conflict(wr0_conflict), .wr1_conflict(wr1_conflict),
        .waddr0(waddr0), .waddr1(waddr1),
        .wmask0(wmask0), .wmask1(wmask1),
        .wdata0(wdata0), .wdata1(wdata1),
        .idle(idle)
    );

    task automatic chk(input string name, input logic [VFULEN-1:0] act,
                       input logic [VFULEN-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    // ---- behavioural model: one queue per source ----
    vrf_wb_entry_t q0[$];
    vrf_wb_entry_t q1[$];
    int  conf_run = 0;
    bit  yielded = 0;

    function automatic void model_out(output bit v0, output bit v1);
        bit give_way;
        give_way = (conf_run == LIMIT) && !yielded;
        v0 = (q0.size() > 0) && !give_way;
        v1 = (q1.size() > 0) && !(v0 && q0[0].waddr == q1[0].waddr);
    endfunction

    // Model state advances with the DUT clock; reset empties everything.
    always @(posedge clk or negedge rstn) begin
        bit v0, v1, p0, p1, give_way;
        vrf_wb_entry_t e;
        if (!rstn) begin
            q0.delete();
            q1.delete();
            conf_run = 0;
            yielded = 0;
        end else begin
            model_out(v0, v1);
            give_way = (conf_run == LIMIT) && !yielded;
            p0 = v0 && !wr0_conflict;
            p1 = v1 && !wr1_conflict;
            if (p1 || q1.size() == 0) begin
                conf_run = 0;
                yielded = 0;
            end else begin
                if (give_way) yielded = 1;
                if (v1 && wr1_conflict && conf_run < LIMIT) conf_run++;
            end
            if (src0_vld && q0.size() < DEPTH) begin
                e.waddr = src0_waddr; e.wmask = src0_wmask; e.wdata = src0_wdata;
                if (p0) void'(q0.pop_front());
                q0.push_back(e);
            end else if (p0) void'(q0.pop_front());
            if (src1_vld && q1.size() < DEPTH) begin
                e.waddr = src1_waddr; e.wmask = src1_wmask; e.wdata = src1_wdata;
                if (p1) void'(q1.pop_front());
                q1.push_back(e);
            end else if (p1) void'(q1.pop_front());
        end
    end

    // Every falling edge: all DUT outputs against the model.
    always @(negedge clk) begin
        bit v0, v1;
        vrf_wb_entry_t h0, h1;
        model_out(v0, v1);
        h0 = v0 ? q0[0] : '0;
        h1 = v1 ? q1[0] : '0;
        chk("wr0_vld", VFULEN'(wr0_vld), VFULEN'(v0));
        chk("wr1_vld", VFULEN'(wr1_vld), VFULEN'(v1));
        chk("waddr0", VFULEN'(waddr0), VFULEN'(h0.waddr));
        chk("waddr1", VFULEN'(waddr1), VFULEN'(h1.waddr));
        chk("wmask0", wmask0, h0.wmask);
        chk("wmask1", wmask1, h1.wmask);
        chk("wdata0", wdata0, h0.wdata);
        chk("wdata1", wdata1, h1.wdata);
        chk("src0_rdy", VFULEN'(src0_rdy), VFULEN'(q0.size() < DEPTH));
        chk("src1_rdy", VFULEN'(src1_rdy), VFULEN'(q1.size() < DEPTH));
        chk("idle", VFULEN'(idle), VFULEN'(q0.size() == 0 && q1.size() == 0));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive0(input bit v, input int a, input logic [VFULEN-1:0] m,
                          input logic [VFULEN-1:0] d);
        src0_vld = v; src0_waddr = VREG_ADDR_WIDTH'(a);
        src0_wmask = m; src0_wdata = d;
    endtask

    task automatic drive1(input bit v, input int a, input logic [VFULEN-1:0] m,
                          input logic [VFULEN-1:0] d);
        src1_vld = v; src1_waddr = VREG_ADDR_WIDTH'(a);
        src1_wmask = m; src1_wdata = d;
    endtask

    initial begin
        tick();
        chk("rst_idle", VFULEN'(idle), 1);
        chk("rst_rdy", VFULEN'({src0_rdy, src1_rdy}), 3);
        chk("rst_wvld", VFULEN'({wr0_vld, wr1_vld}), 0);
        tick();
        rstn = 1'b1;
        tick();

        // single write through port 0
        drive0(1, 3, ONES, 64'hA5A5_A5A5_A5A5_A5A5);
        tick();
        drive0(0, 0, '0, '0);
        chk("t1_vld", VFULEN'(wr0_vld), 1);
        chk("t1_addr", VFULEN'(waddr0), 3);
        chk("t1_mask", wmask0, ONES);
        chk("t1_data", wdata0, 64'hA5A5_A5A5_A5A5_A5A5);
        chk("t1_busy", VFULEN'(idle), 0);
        tick();
        chk("t1_vld_off", VFULEN'(wr0_vld), 0);
        chk("t1_idle", VFULEN'(idle), 1);

        // fill port 1 under conflict, then drain in order
        wr1_conflict = 1;
        for (int i = 0; i < 4; i++) begin
            drive1(1, 10 + i, 64'(i + 1), 64'h100 + 64'(i));
            tick();
        end
        chk("t2_full", VFULEN'(src1_rdy), 0);
        drive1(1, 20, ONES, 64'hDEAD);
        tick();
        drive1(0, 0, '0, '0);
        tick();
        chk("t2_hold_addr", VFULEN'(waddr1), 10);
        chk("t2_hold_data", wdata1, 64'h100);
        wr1_conflict = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", VFULEN'(waddr1), VFULEN'(10 + i));
            tick();
        end
        chk("t2_empty", VFULEN'(wr1_vld), 0);
        chk("t2_idle", VFULEN'(idle), 1);

        // same destination on both heads
        drive0(1, 5, ONES, 64'h55);
        drive1(1, 5, ONES, 64'h66);
        tick();
        drive0(0, 0, '0, '0);
        drive1(0, 0, '0, '0);
        chk("t3_c1_w0", VFULEN'(wr0_vld), 1);
        chk("t3_c1_w1", VFULEN'(wr1_vld), 0);
        tick();
        chk("t3_c2_w0", VFULEN'(wr0_vld), 0);
        chk("t3_c2_w1", VFULEN'(wr1_vld), 1);
        chk("t3_c2_d1", wdata1, 64'h66);
        tick();

        // starvation: port 0 yields once after 8 refused port-1 cycles
        wr0_conflict = 1;
        wr1_conflict = 1;
        drive0(1, 1, ONES, 64'h11);
        drive1(1, 2, ONES, 64'h22);
        tick();
        drive0(0, 0, '0, '0);
        drive1(0, 0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            chk("t4_w0_on", VFULEN'(wr0_vld), 1);
            tick();
        end
        chk("t4_yield", VFULEN'(wr0_vld), 0);
        chk("t4_w1", VFULEN'(wr1_vld), 1);
        tick();
        chk("t4_once", VFULEN'(wr0_vld), 1);
        wr1_conflict = 0;
        tick();
        chk("t4_w1_pop", VFULEN'(wr1_vld), 0);
        chk("t4_w0_back", VFULEN'(wr0_vld), 1);
        wr0_conflict = 0;
        tick();
        chk("t4_idle", VFULEN'(idle), 1);

        // mixed traffic on both sources
        for (int i = 0; i < 24; i++) begin
            drive0(i % 2 == 0, i % 4, 64'(i) << 8, 64'h1000 + 64'(i));
            drive1(i % 3 != 2, i % 5, ~64'(i), 64'h2000 + 64'(i));
            wr0_conflict = (i % 4 == 3);
            wr1_conflict = (i % 3 == 0);
            tick();
        end
        drive0(0, 0, '0, '0);
        drive1(0, 0, '0, '0);
        wr0_conflict = 0;
        wr1_conflict = 0;
        for (int i = 0; i < 12; i++) tick();
        chk("t5_drained", VFULEN'(idle), 1);

        // reset while entries are buffered
        wr0_conflict = 1;
        for (int i = 0; i < 3; i++) begin
            drive0(1, 7 + i, ONES, 64'(i));
            tick();
        end
        drive0(0, 0, '0, '0);
        chk("t6_busy", VFULEN'(wr0_vld), 1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_vld", VFULEN'(wr0_vld), 0);
        chk("t6_rst_idle", VFULEN'(idle), 1);
        chk("t6_rst_rdy", VFULEN'(src0_rdy), 1);
        tick();
        rstn = 1'b1;
        wr0_conflict = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_wr", VFULEN'({wr0_vld, wr1_vld}), 0);
        end
        chk("t6_idle", VFULEN'(idle), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vrf_wb_arbiter.md
VRF_WB_ARBITER -- requirements
Module: vrf_wb_arbiter

Interface
REQ-001 Parameter WB_FIFO_DEPTH, default 4, entries per source buffer; power of two and at least 2.
REQ-002 Parameter STARVE_LIMIT, default 8, number of consecutive wr1 conflict cycles before port 0 yields.
REQ-003 clk  in  1  single clock; all state is updated on its rising edge.
REQ-004 rstn  in  1  reset; asynchronous assertion, active-low.
REQ-005 src0_vld / src1_vld  in  1 each  functional-unit result valid.
REQ-006 src0_rdy / src1_rdy  out  1 each  buffer can accept a result.
REQ-007 src0_waddr / src1_waddr  in  VREG_ADDR_WIDTH each  destination vreg slice.
REQ-008 src0_wmask / src1_wmask  in  VFULEN each  bit write mask.
REQ-009 src0_wdata / src1_wdata  in  VFULEN each  write data.
REQ-010 wr0_vld / wr1_vld  out  1 each  regfile write request.
REQ-011 wr0_conflict / wr1_conflict  in  1 each  regfile refused the write this cycle.
REQ-012 waddr0 / waddr1  out  VREG_ADDR_WIDTH each  regfile write address.
REQ-013 wmask0 / wmask1  out  VFULEN each  regfile write mask.
REQ-014 wdata0 / wdata1  out  VFULEN each  regfile write data.
REQ-015 idle  out  1  both buffers empty.

Function
REQ-016 Each source N (0 or 1) SHALL own an in-order FIFO of WB_FIFO_DEPTH entries; each entry holds {waddr, wmask, wdata}.
REQ-017 srcN_rdy SHALL equal NOT full of FIFO N; there is no same-cycle pop-to-push bypass when the FIFO is full.
REQ-018 A push SHALL occur on srcN_vld & srcN_rdy; an entry pushed at edge t SHALL first appear on port N in the cycle after edge t; there is no zero-latency bypass.
REQ-019 wrN_vld SHALL be high while FIFO N is non-empty, except when masked by REQ-022 or REQ-023.
REQ-020 waddrN, wmaskN and wdataN SHALL present the FIFO N head when wrN_vld=1, and SHALL be 0 when wrN_vld=0.
REQ-021 A pop SHALL occur on wrN_vld & ~wrN_conflict; on conflict the head SHALL be held unchanged and re-presented in the next cycle.
REQ-022 When both heads are valid and their waddr values are equal, wr1_vld SHALL be 0 for that cycle, so port 0 writes first.
REQ-023 A 0..STARVE_LIMIT saturating counter SHALL:
  - increment on each wr1_vld & wr1_conflict cycle;
  - clear on a wr1 pop or when FIFO 1 is empty.
  When the counter equals STARVE_LIMIT, wr0_vld SHALL be forced to 0 for exactly one cycle; the counter is unaffected by this yield cycle's outcome other than per the rules above.
REQ-024 A simultaneous push and pop on the same FIFO SHALL leave occupancy unchanged; pointers SHALL wrap modulo WB_FIFO_DEPTH.
REQ-025 idle SHALL be high exactly when both FIFOs are empty.
REQ-026 Writes from one source SHALL reach the regfile in arrival order; no ordering is guaranteed between sources, except per REQ-022.

Reset
REQ-027 While rstn=0:
  - both FIFOs SHALL be empty, with pointers 0;
  - the starve counter and the yield flag SHALL be 0;
  - wr0_vld = wr1_vld = 0 and all address/mask/data outputs SHALL be 0;
  - idle = 1 and src0_rdy = src1_rdy = 1.
REQ-028 Reset asserted mid-operation SHALL discard all buffered entries without emitting any write.

Structure
REQ-029 VREG_ADDR_WIDTH, VFULEN and VRF_WPORT_NUM SHALL come from rrv64_core_vec_param_pkg.
REQ-030 A new typedef vrf_wb_entry_t {waddr, wmask, wdata} SHALL be added to rrv64_core_vec_param_pkg.
REQ-031 The FIFO SHALL be a sub-module vrf_wb_fifo, instantiated twice; arbitration and starvation logic SHALL reside in the top module.

Verification
REQ-032 Push src0 {waddr=3, wmask=all-ones, wdata=0xA5..} with conflicts held at 0 -> wr0_vld=1 one cycle later with identical fields, FIFO empties, idle returns to 1.
REQ-033 Fill src1 with 4 entries and hold wr1_conflict=1 -> src1_rdy=0 after the fourth push; outputs stay constant; releasing the conflict drains the entries in order over 4 cycles.
REQ-034 Both heads carry waddr=5 -> wr0 writes in cycle 1 with wr1_vld=0; wr1 writes in cycle 2.
REQ-035 Both FIFOs non-empty and wr1_conflict=1 for 8 cycles -> wr0_vld=0 in the 9th cycle; wr1 pops once wr1_conflict is dropped.
REQ-036 Assert rstn=0 with 3 entries buffered -> wr*_vld drop immediately, idle=1 and no writes after release.
